// File: rtl/waveform_to_pipe_bram.sv
// Dual-clock capture buffer: records DEPTH 32-bit samples on sample_clk after an arm pulse,
// then streams them to the host as 16-bit okBTPipeOut words on pipe_clk.
`timescale 1ns/1ps
module waveform_to_pipe_bram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              reset_global,
  input  logic              sample_clk,
  input  logic              pipe_clk,
  input  logic              arm,
  input  logic              sample_en,
  input  logic [31:0]       sample_in,
  output logic              capture_busy,
  output logic              capture_done,
  output logic [ADDR_W:0]   samples_captured,
  input  logic              pipe_out_read,
  output logic [15:0]       pipe_out_data,
  output logic              pipe_out_ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StFill, StDone} cap_state_e;

  cap_state_e          state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic                wr_en;
  logic [31:0]         mem [DEPTH];

  // ---------------- capture side (sample_clk) ----------------
  assign wr_en = (state_q == StFill) && sample_en;

  always_ff @(posedge sample_clk or posedge reset_global) begin
    if (reset_global) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      samples_captured <= '0;
      capture_busy     <= 1'b0;
      capture_done     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          // arm wins over a coincident sample_en; that sample is dropped
          if (arm) begin
            state_q          <= StFill;
            wr_ptr_q         <= '0;
            samples_captured <= '0;
            capture_busy     <= 1'b1;
            capture_done     <= 1'b0;
          end
        end
        StFill: begin
          if (sample_en) begin
            wr_ptr_q         <= wr_ptr_q + 1'b1;
            samples_captured <= samples_captured + 1'b1;
            if (&wr_ptr_q) begin
              state_q      <= StDone;
              capture_busy <= 1'b0;
              capture_done <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= StIdle;
          capture_busy <= 1'b0;
          capture_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sample_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= sample_in;
    end
  end

  // ---------------- read side (pipe_clk) ----------------
  logic              done_s1_q, done_s2_q, done_q;
  logic              done_rise, done_fall;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              ready_q, ready_d;
  logic [31:0]       rd_word_q;

  assign done_rise = done_s2_q & ~done_q;
  assign done_fall = ~done_s2_q & done_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    ready_d  = ready_q;
    if (done_rise) begin
      rd_ptr_d = '0;
      ready_d  = 1'b1;
    end else if (done_fall) begin
      rd_ptr_d = '0;
      ready_d  = 1'b0;
    end else if (pipe_out_read && ready_q) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (&rd_ptr_q) begin
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pipe_clk or posedge reset_global) begin
    if (reset_global) begin
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      done_q    <= 1'b0;
      rd_ptr_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      done_s1_q <= capture_done;
      done_s2_q <= done_s1_q;
      done_q    <= done_s2_q;
      rd_ptr_q  <= rd_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Registered read addressed by the next pointer, so the word is already present when used
  always_ff @(posedge pipe_clk) begin
    rd_word_q <= mem[rd_ptr_d[ADDR_W:1]];
  end

  assign pipe_out_ready = ready_q;
  assign pipe_out_data  = !ready_q   ? 16'h0000 :
                          rd_ptr_q[0] ? rd_word_q[31:16] : rd_word_q[15:0];

endmodule

// File: tb/tb_waveform_to_pipe_bram.sv
// Scoreboard bench for waveform_to_pipe_bram: captures push expected pipe words, a pipe-side
// monitor issues reads and pops/compares them.
`timescale 1ns/1ps
module tb_waveform_to_pipe_bram;

  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          reset_global = 1'b0;
  logic          sample_clk = 1'b0;
  logic          pipe_clk = 1'b0;
  logic          arm = 1'b0;
  logic          sample_en = 1'b0;
  logic [31:0]   sample_in = '0;
  logic          capture_busy, capture_done;
  logic [AW:0]   samples_captured;
  logic          pipe_out_read = 1'b0;
  logic [15:0]   pipe_out_data;
  logic          pipe_out_ready;

  int total = 0;
  int bad = 0;
  int rd_budget = 0;
  bit rd_dense = 1'b0;
  logic [15:0] exp_q[$];

  always #5 sample_clk = ~sample_clk;
  always #7 pipe_clk = ~pipe_clk;

  waveform_to_pipe_bram #(.ADDR_W(AW)) dut (
    .reset_global     (reset_global),
    .sample_clk       (sample_clk),
    .pipe_clk         (pipe_clk),
    .arm              (arm),
    .sample_en        (sample_en),
    .sample_in        (sample_in),
    .capture_busy     (capture_busy),
    .capture_done     (capture_done),
    .samples_captured (samples_captured),
    .pipe_out_read    (pipe_out_read),
    .pipe_out_data    (pipe_out_data),
    .pipe_out_ready   (pipe_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipe-side reader and monitor: decides the read for the coming edge and scores the word
  always @(negedge pipe_clk) begin
    logic rd;
    logic [15:0] w;
    rd = (rd_budget > 0) && (rd_dense || ($urandom_range(3) != 0));
    if (rd && pipe_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {16'h0, pipe_out_data}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("pipe_word", {16'h0, pipe_out_data}, {16'h0, w});
      end
      rd_budget--;
    end else if (rd) begin
      chk("idle_read_data", {16'h0, pipe_out_data}, 32'h0);
    end
    pipe_out_read = rd;
  end

  // mode 0: ramp base+i, 1: random values. gap 0: dense, 1: alternate, 2: random.
  task automatic capture(input int mode, input logic [31:0] base, input int gap,
                         input bit arm_mid, input bit en_on_arm, input bit flush,
                         input int rst_at);
    logic [31:0] stored[$];
    logic [31:0] v;
    int n = 0;
    int cyc = 0;
    bit en;
    @(negedge sample_clk);
    arm = 1'b1;
    sample_en = en_on_arm;
    sample_in = 32'hDEAD_BEEF;
    @(negedge sample_clk);
    arm = 1'b0;
    if (flush) exp_q.delete();
    chk("busy_after_arm", {31'h0, capture_busy}, 32'h1);
    chk("done_after_arm", {31'h0, capture_done}, 32'h0);
    chk("count_after_arm", {27'h0, samples_captured}, 32'h0);
    while (n < DEPTH && cyc < 200) begin
      cyc++;
      en = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : ($urandom_range(2) != 0);
      v = (mode == 0) ? base + 32'(n) : $urandom;
      sample_en = en;
      sample_in = v;
      arm = arm_mid && (n == 5) && en;
      if (rst_at >= 0 && n == rst_at) begin
        #3 reset_global = 1'b1;
        #1;
        chk("rst_busy", {31'h0, capture_busy}, 32'h0);
        chk("rst_done", {31'h0, capture_done}, 32'h0);
        chk("rst_count", {27'h0, samples_captured}, 32'h0);
        chk("rst_ready", {31'h0, pipe_out_ready}, 32'h0);
        chk("rst_data", {16'h0, pipe_out_data}, 32'h0);
        @(negedge sample_clk);
        reset_global = 1'b0;
        sample_en = 1'b0;
        arm = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge sample_clk);
      if (en) begin
        stored.push_back(v);
        n++;
      end
      chk("count", {27'h0, samples_captured}, 32'(n));
      chk("done_level", {31'h0, capture_done}, {31'h0, n == DEPTH});
      chk("busy_level", {31'h0, capture_busy}, {31'h0, n != DEPTH});
    end
    sample_en = 1'b0;
    arm = 1'b0;
    if (n != DEPTH) chk("capture_timeout", 32'(n), 32'(DEPTH));
    if (gap == 1) chk("gapped_done_cycle", 32'(cyc), 32'd32);
    foreach (stored[i]) begin
      exp_q.push_back(stored[i][15:0]);
      exp_q.push_back(stored[i][31:16]);
    end
  endtask

  task automatic drain();
    int t = 0;
    rd_budget = 100000;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge pipe_clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
    @(negedge pipe_clk);
    @(negedge pipe_clk);
    chk("ready_after_last", {31'h0, pipe_out_ready}, 32'h0);
    rd_budget = 0;
    rd_dense = 1'b0;
  endtask

  initial begin
    int t;
    #2 reset_global = 1'b1;
    #1;
    chk("reset_busy", {31'h0, capture_busy}, 32'h0);
    chk("reset_done", {31'h0, capture_done}, 32'h0);
    chk("reset_count", {27'h0, samples_captured}, 32'h0);
    chk("reset_ready", {31'h0, pipe_out_ready}, 32'h0);
    chk("reset_data", {16'h0, pipe_out_data}, 32'h0);
    #20 reset_global = 1'b0;

    // Ramp, then full-rate readback
    capture(0, 32'hA000_0000, 0, 1'b0, 1'b0, 1'b0, -1);
    rd_dense = 1'b1;
    drain();

    // Alternate sample_en
    capture(0, 32'h5555_0000, 1, 1'b0, 1'b0, 1'b0, -1);
    drain();

    // Reads issued during the fill
    rd_budget = 100000;
    capture(1, 32'h0, 2, 1'b0, 1'b0, 1'b0, -1);
    drain();

    // arm during FILL ignored; also arm with sample_en coincident in DONE
    capture(0, 32'hC000_0000, 0, 1'b1, 1'b1, 1'b0, -1);
    drain();

    // Partial read of 10 words, then re-arm with a ramp from 1
    capture(0, 32'hB000_0000, 2, 1'b0, 1'b0, 1'b0, -1);
    rd_budget = 10;
    t = 0;
    while (rd_budget != 0 && t < 200) begin
      @(negedge pipe_clk);
      t++;
    end
    chk("partial_read_done", 32'(rd_budget), 32'h0);
    capture(0, 32'h0000_0001, 0, 1'b0, 1'b1, 1'b1, -1);
    chk("ready_dropped_on_rearm", {31'h0, pipe_out_ready}, 32'h0);
    drain();

    // Reset mid-capture, then a clean capture
    capture(0, 32'h7000_0000, 0, 1'b0, 1'b0, 1'b0, 7);
    capture(0, 32'h7100_0000, 2, 1'b0, 1'b0, 1'b1, -1);
    drain();

    for (int k = 0; k < 3; k++) begin
      capture(1, 32'h0, 2, 1'b0, 1'b0, 1'b0, -1);
      rd_dense = k[0];
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
